raster_scan_ctrl: RTL and testbench
===================================

Name: raster_scan_ctrl

Overview:
Sequencer for the combinational barycentric rasterizer datapath. Accepts one triangle setup plus a screen bounding box, then walks the box one pixel per cycle in row-major order and drives the datapath's pixel x/y. It emits only visible pixels as fragments on a valid/ready stream carrying position and the four weight outputs. It sits between triangle setup and the fragment/depth stage, and owns the rasterizer instance's inputs.

Parameters:
SCREEN_W, 640, horizontal resolution; box max_x clamped to SCREEN_W-1
SCREEN_H, 480, vertical resolution; box max_y clamped to SCREEN_H-1

Ports:
clk  in  1  the block's single clock
rst_n  in  1  reset; asynchronous, active-low
tri_valid  in  1  triangle setup offered
tri_ready  out  1  high only in IDLE
tri_ax, tri_ay, tri_abx, tri_aby, tri_bz, tri_acx, tri_acy, tri_cz  in  9,7,8s,9s,7,8s,9s,7  setup terms (s = signed)
tri_min_x, tri_max_x, tri_min_y, tri_max_y  in  10 each  inclusive bounding box
r_ax..r_cz  out  same widths as tri_*  registered setup to datapath
r_x, r_y  out  10 each  current pixel
r_uw, r_vw, r_ww  in  18 each  datapath weights
r_aw  in  19  datapath weight sum
r_visible  in  1  datapath coverage
frag_valid  out  1  fragment held
frag_ready  in  1  downstream accepts
frag_x, frag_y  out  10 each
frag_uw, frag_vw, frag_ww  out  18 each
frag_aw  out  19
done  out  1  one-cycle pulse at triangle completion
frag_count  out  19  fragments emitted for last/current triangle

Behaviour:
- Reset values (async, rst_n low): state IDLE; all r_* 0; frag_valid 0; all frag_* 0; done 0; frag_count 0. tri_ready = (state==IDLE), so it reads 1 during and after reset.
- States: IDLE, SCAN, FLUSH, DONE.
- IDLE, on tri_valid && tri_ready:
  - Latch setup into r_*.
  - Store mx=min(tri_max_x,SCREEN_W-1), my=min(tri_max_y,SCREEN_H-1).
  - r_x<=tri_min_x, r_y<=tri_min_y; clear frag_count.
  - If tri_min_x>mx or tri_min_y>my (empty box), go to DONE. Otherwise go to SCAN.
- SCAN: adv = !frag_valid || frag_ready.
  - When adv: if r_visible, load frag_* from r_x/r_y/r_uw/r_vw/r_ww/r_aw, set frag_valid=1, frag_count+1. Else frag_valid<=0.
  - Also when adv, step the pixel. If r_x==mx: r_x<=min_x; if r_y==my, go to FLUSH, else r_y+1. Otherwise r_x+1.
  - When !adv: r_x, r_y and frag_* hold.
- Pixel (x,y) is evaluated in the cycle it sits on r_x/r_y. Its fragment appears on frag_* the next cycle. Throughput is 1 pixel/cycle with frag_ready high; a box of N pixels spends exactly N SCAN cycles.
- frag_* are stable while frag_valid && !frag_ready (standard valid/ready; valid never drops without acceptance).
- FLUSH: when !frag_valid or frag_ready, clear frag_valid and go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. frag_count holds until the next triangle is accepted.
- Widths: r_x/r_y increment never exceeds mx/my, so no wrap. tri_min beyond the screen yields the empty-box path.
- Reset mid-operation aborts immediately. No fragment or done is produced for the aborted triangle.

Decomposition:
- Shared package raster_pkg:
  - typedef tri_setup_t bundling ax..cz with the widths above
  - typedef frag_t {x,y,uw,vw,ww,aw}
  - state enum
  - constants SCREEN_W/H defaults, coordinate width 10
- One sub-module is natural: frag_out_reg (single-entry valid/ready output register with hold). The existing rasterizer is instantiated by the parent pipeline, not inside this block.

Test Plan:
- Reset: rst_n low mid-cycle -> tri_ready=1, frag_valid=0, done=0, frag_count=0 without waiting for a clock edge.
- 1x1 box (min=max=(5,7)), r_visible=1, frag_ready=1 -> one fragment frag_x=5, frag_y=7 with weights equal to the r_* values of that cycle; done pulses 3 cycles after accept; frag_count=1.
- 4x2 box at (0,0), visible only on pixel (2,1) -> r_x/r_y sequence (0,0),(1,0),(2,0),(3,0),(0,1)...(3,1); single fragment (2,1); frag_count=1.
- Backpressure: 2x1 box all visible, frag_ready=0 for 5 cycles -> frag_*=(x0,y0) frozen, r_x frozen; release -> second fragment next cycle; done after it is accepted.
- Clamp/empty: tri_max_x=700 -> last r_x=639. tri_min_x=10, tri_max_x=9 -> no fragments; done pulses the cycle after accept.
- Reset mid-SCAN of a 16x16 box -> outputs return to reset values; the next triangle scans correctly from its own min.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared types and constants for the raster scan sequencer and its output register.
package raster_pkg;

  localparam int COORD_W      = 10;
  localparam int WGT_W        = 18;
  localparam int SUM_W        = 19;
  localparam int CNT_W        = 19;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_DONE
  } scan_state_e;

  typedef struct packed {
    logic        [8:0] ax;
    logic        [6:0] ay;
    logic signed [7:0] abx;
    logic signed [8:0] aby;
    logic        [6:0] bz;
    logic signed [7:0] acx;
    logic signed [8:0] acy;
    logic        [6:0] cz;
  } tri_setup_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [WGT_W-1:0]   uw;
    logic [WGT_W-1:0]   vw;
    logic [WGT_W-1:0]   ww;
    logic [SUM_W-1:0]   aw;
  } frag_t;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/frag_out_reg.sv
// Single-entry valid/ready output register; contents hold whenever en_i is low.
module frag_out_reg
  import raster_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  logic  load_i,
  input  frag_t data_i,
  output logic  valid_o,
  output frag_t data_o
);

  logic  valid_q;
  frag_t data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= load_i;
      if (load_i) data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/raster_scan_ctrl.sv
// Walks a triangle's clamped bounding box row-major, one pixel per cycle, and
// forwards covered pixels from the barycentric datapath as a fragment stream.
module raster_scan_ctrl
  import raster_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  input  logic               [8:0]  tri_ax,
  input  logic               [6:0]  tri_ay,
  input  logic signed        [7:0]  tri_abx,
  input  logic signed        [8:0]  tri_aby,
  input  logic               [6:0]  tri_bz,
  input  logic signed        [7:0]  tri_acx,
  input  logic signed        [8:0]  tri_acy,
  input  logic               [6:0]  tri_cz,
  input  logic [COORD_W-1:0]        tri_min_x,
  input  logic [COORD_W-1:0]        tri_max_x,
  input  logic [COORD_W-1:0]        tri_min_y,
  input  logic [COORD_W-1:0]        tri_max_y,
  output logic               [8:0]  r_ax,
  output logic               [6:0]  r_ay,
  output logic signed        [7:0]  r_abx,
  output logic signed        [8:0]  r_aby,
  output logic               [6:0]  r_bz,
  output logic signed        [7:0]  r_acx,
  output logic signed        [8:0]  r_acy,
  output logic               [6:0]  r_cz,
  output logic [COORD_W-1:0]        r_x,
  output logic [COORD_W-1:0]        r_y,
  input  logic [WGT_W-1:0]          r_uw,
  input  logic [WGT_W-1:0]          r_vw,
  input  logic [WGT_W-1:0]          r_ww,
  input  logic [SUM_W-1:0]          r_aw,
  input  logic                      r_visible,
  output logic                      frag_valid,
  input  logic                      frag_ready,
  output logic [COORD_W-1:0]        frag_x,
  output logic [COORD_W-1:0]        frag_y,
  output logic [WGT_W-1:0]          frag_uw,
  output logic [WGT_W-1:0]          frag_vw,
  output logic [WGT_W-1:0]          frag_ww,
  output logic [SUM_W-1:0]          frag_aw,
  output logic                      done,
  output logic [CNT_W-1:0]          frag_count
);

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H - 1);

  scan_state_e        state_q, state_d;
  tri_setup_t         setup_q, setup_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] min_x_q, min_x_d, max_x_q, max_x_d, max_y_q, max_y_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [COORD_W-1:0] clamp_x, clamp_y;
  logic               adv, fo_en, fo_load, fo_valid;
  frag_t              fo_data_in, fo_data;

  assign clamp_x    = clamp_coord(tri_max_x, MAX_X);
  assign clamp_y    = clamp_coord(tri_max_y, MAX_Y);
  assign adv        = !fo_valid || frag_ready;
  assign fo_data_in = '{x: x_q, y: y_q, uw: r_uw, vw: r_vw, ww: r_ww, aw: r_aw};

  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    x_d     = x_q;
    y_d     = y_q;
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fo_en   = 1'b0;
    fo_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tri_valid) begin
          setup_d = '{ax: tri_ax, ay: tri_ay, abx: tri_abx, aby: tri_aby,
                      bz: tri_bz, acx: tri_acx, acy: tri_acy, cz: tri_cz};
          x_d     = tri_min_x;
          y_d     = tri_min_y;
          min_x_d = tri_min_x;
          max_x_d = clamp_x;
          max_y_d = clamp_y;
          cnt_d   = '0;
          // A min corner past the clamped max (incl. off-screen) is an empty box
          if (tri_min_x > clamp_x || tri_min_y > clamp_y) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (adv) begin
          fo_en   = 1'b1;
          fo_load = r_visible;
          if (r_visible) cnt_d = cnt_q + 1'b1;
          if (x_q == max_x_q) begin
            x_d = min_x_q;
            if (y_q == max_y_q) state_d = ST_FLUSH;
            else                y_d     = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (adv) begin
          fo_en   = 1'b1;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      setup_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      setup_q <= setup_d;
      x_q     <= x_d;
      y_q     <= y_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  frag_out_reg u_frag_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (fo_en),
    .load_i  (fo_load),
    .data_i  (fo_data_in),
    .valid_o (fo_valid),
    .data_o  (fo_data)
  );

  assign tri_ready  = (state_q == ST_IDLE);
  assign r_ax       = setup_q.ax;
  assign r_ay       = setup_q.ay;
  assign r_abx      = setup_q.abx;
  assign r_aby      = setup_q.aby;
  assign r_bz       = setup_q.bz;
  assign r_acx      = setup_q.acx;
  assign r_acy      = setup_q.acy;
  assign r_cz       = setup_q.cz;
  assign r_x        = x_q;
  assign r_y        = y_q;
  assign frag_valid = fo_valid;
  assign frag_x     = fo_data.x;
  assign frag_y     = fo_data.y;
  assign frag_uw    = fo_data.uw;
  assign frag_vw    = fo_data.vw;
  assign frag_ww    = fo_data.ww;
  assign frag_aw    = fo_data.aw;
  assign done       = done_q;
  assign frag_count = cnt_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: a stub datapath derives coverage and weights from
// the pixel position, and a box-walk model predicts the fragment stream.
module tb_raster_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tri_valid = 1'b0;
  logic tri_ready;
  logic        [8:0] tri_ax = '0;
  logic        [6:0] tri_ay = '0;
  logic signed [7:0] tri_abx = '0;
  logic signed [8:0] tri_aby = '0;
  logic        [6:0] tri_bz = '0;
  logic signed [7:0] tri_acx = '0;
  logic signed [8:0] tri_acy = '0;
  logic        [6:0] tri_cz = '0;
  logic [9:0] tri_min_x = '0, tri_max_x = '0, tri_min_y = '0, tri_max_y = '0;
  logic        [8:0] r_ax;
  logic        [6:0] r_ay;
  logic signed [7:0] r_abx;
  logic signed [8:0] r_aby;
  logic        [6:0] r_bz;
  logic signed [7:0] r_acx;
  logic signed [8:0] r_acy;
  logic        [6:0] r_cz;
  logic [9:0]  r_x, r_y;
  logic [17:0] r_uw, r_vw, r_ww;
  logic [18:0] r_aw;
  logic        r_visible;
  logic        frag_valid;
  logic        frag_ready = 1'b0;
  logic [9:0]  frag_x, frag_y;
  logic [17:0] frag_uw, frag_vw, frag_ww;
  logic [18:0] frag_aw;
  logic        done;
  logic [18:0] frag_count;

  int n_tests = 0;
  int n_fail  = 0;
  int vis_mode = 0, vis_px = 0, vis_py = 0, seed = 0;
  logic [63:0] exp_setup;

  always #5 clk = ~clk;

  raster_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_ax(tri_ax), .tri_ay(tri_ay), .tri_abx(tri_abx), .tri_aby(tri_aby),
    .tri_bz(tri_bz), .tri_acx(tri_acx), .tri_acy(tri_acy), .tri_cz(tri_cz),
    .tri_min_x(tri_min_x), .tri_max_x(tri_max_x), .tri_min_y(tri_min_y), .tri_max_y(tri_max_y),
    .r_ax(r_ax), .r_ay(r_ay), .r_abx(r_abx), .r_aby(r_aby),
    .r_bz(r_bz), .r_acx(r_acx), .r_acy(r_acy), .r_cz(r_cz),
    .r_x(r_x), .r_y(r_y), .r_uw(r_uw), .r_vw(r_vw), .r_ww(r_ww), .r_aw(r_aw),
    .r_visible(r_visible), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_uw(frag_uw), .frag_vw(frag_vw),
    .frag_ww(frag_ww), .frag_aw(frag_aw), .done(done), .frag_count(frag_count)
  );

  // Stub datapath: coverage and weights are pure functions of pixel and seed
  function automatic bit vis_f(int x, int y, int mode, int px, int py, int s);
    case (mode)
      0:       return 1'b1;
      1:       return ((x * 7 + y * 13 + s) % 4) != 0;
      default: return (x == px) && (y == py);
    endcase
  endfunction
  function automatic logic [17:0] uw_f(int x, int y, int s); return 18'(x * 37 + y * 11 + s); endfunction
  function automatic logic [17:0] vw_f(int x, int y, int s); return 18'((x * 1021) ^ (y * 77) ^ s); endfunction
  function automatic logic [17:0] ww_f(int x, int y, int s); return 18'(s * 5 - x - y); endfunction
  function automatic logic [18:0] aw_f(int x, int y, int s); return 19'(x * 3 + y * 5 + s * 2 + 70000); endfunction

  always_comb begin
    r_visible = vis_f(int'(r_x), int'(r_y), vis_mode, vis_px, vis_py, seed);
    r_uw      = uw_f(int'(r_x), int'(r_y), seed);
    r_vw      = vw_f(int'(r_x), int'(r_y), seed);
    r_ww      = ww_f(int'(r_x), int'(r_y), seed);
    r_aw      = aw_f(int'(r_x), int'(r_y), seed);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic scramble_tri();
    tri_ax  = 9'($urandom);  tri_ay  = 7'($urandom);
    tri_abx = 8'($urandom);  tri_aby = 9'($urandom);
    tri_bz  = 7'($urandom);  tri_acx = 8'($urandom);
    tri_acy = 9'($urandom);  tri_cz  = 7'($urandom);
  endtask

  // Offers a triangle and returns #1 after the accepting edge
  task automatic start_tri(input int minx, input int maxx, input int miny, input int maxy);
    int c;
    @(negedge clk);
    scramble_tri();
    exp_setup = {tri_ax, tri_ay, tri_abx, tri_aby, tri_bz, tri_acx, tri_acy, tri_cz};
    tri_min_x = 10'(minx); tri_max_x = 10'(maxx);
    tri_min_y = 10'(miny); tri_max_y = 10'(maxy);
    tri_valid = 1'b1;
    c = 0;
    while (!tri_ready && c < 100) begin @(negedge clk); c++; end
    if (!tri_ready) begin
      n_tests++; n_fail++;
      $display("FAIL start_tri: tri_ready got 0 want 1 after %0d cycles", c);
    end
    @(posedge clk); #1;
    tri_valid = 1'b0;
    scramble_tri();
  endtask

  task automatic run_triangle(input int minx, input int maxx, input int miny, input int maxy,
                              input int ready_pct, input string tag);
    int qx[$], qy[$];
    int mx, my, n_pix, w, c, exp_cnt;
    bit got_done, prev_stall;
    logic [92:0] prev_frag;
    mx = (maxx > 639) ? 639 : maxx;
    my = (maxy > 479) ? 479 : maxy;
    n_pix = 0;
    w = mx - minx + 1;
    if (minx <= mx && miny <= my) begin
      n_pix = w * (my - miny + 1);
      for (int y = miny; y <= my; y++)
        for (int x = minx; x <= mx; x++)
          if (vis_f(x, y, vis_mode, vis_px, vis_py, seed)) begin qx.push_back(x); qy.push_back(y); end
    end
    exp_cnt = qx.size();
    frag_ready = 1'b1;
    start_tri(minx, maxx, miny, maxy);
    c = 0; got_done = 0; prev_stall = 0; prev_frag = '0;
    while (c < 20 * (n_pix + 4) + 50) begin
      @(negedge clk); c++;
      if (c == 1) begin
        n_tests++;
        if ({r_ax, r_ay, r_abx, r_aby, r_bz, r_acx, r_acy, r_cz} !== exp_setup) begin
          n_fail++;
          $display("FAIL %s setup latch: got %h want %h", tag,
                   {r_ax, r_ay, r_abx, r_aby, r_bz, r_acx, r_acy, r_cz}, exp_setup);
        end
      end
      if (ready_pct == 100 && c <= n_pix) begin
        n_tests++;
        if (r_x !== 10'(minx + (c - 1) % w) || r_y !== 10'(miny + (c - 1) / w)) begin
          n_fail++;
          $display("FAIL %s pixel order c=%0d: got (%0d,%0d) want (%0d,%0d)", tag, c,
                   r_x, r_y, minx + (c - 1) % w, miny + (c - 1) / w);
        end
      end
      if (prev_stall) begin
        n_tests++;
        if ({frag_valid, frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw} !== {1'b1, prev_frag}) begin
          n_fail++;
          $display("FAIL %s stall hold: got v=%0b %h want v=1 %h", tag, frag_valid,
                   {frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw}, prev_frag);
        end
      end
      if (done) begin got_done = 1; break; end
      frag_ready = ($urandom_range(0, 99) < ready_pct);
      if (frag_valid && frag_ready) begin
        n_tests++;
        if (qx.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra fragment: got (%0d,%0d) want none", tag, frag_x, frag_y);
        end else begin
          if ({frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw} !==
              {10'(qx[0]), 10'(qy[0]), uw_f(qx[0], qy[0], seed), vw_f(qx[0], qy[0], seed),
               ww_f(qx[0], qy[0], seed), aw_f(qx[0], qy[0], seed)}) begin
            n_fail++;
            $display("FAIL %s fragment: got (%0d,%0d) w=%h/%h/%h/%h want (%0d,%0d)", tag,
                     frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw, qx[0], qy[0]);
          end
          void'(qx.pop_front()); void'(qy.pop_front());
        end
      end
      prev_stall = frag_valid && !frag_ready;
      prev_frag  = {frag_x, frag_y, frag_uw, frag_vw, frag_ww, frag_aw};
    end
    n_tests++;
    if (!got_done) begin
      n_fail++;
      $display("FAIL %s done timeout: got no done in %0d cycles want done", tag, c);
    end else begin
      n_tests++;
      if (qx.size() != 0 || frag_count !== 19'(exp_cnt) || frag_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s completion: got count=%0d left=%0d valid=%0b want count=%0d left=0 valid=0",
                 tag, frag_count, qx.size(), frag_valid, exp_cnt);
      end
      if (ready_pct == 100) begin
        n_tests++;
        if (c != ((n_pix > 0) ? n_pix + 2 : 1)) begin
          n_fail++;
          $display("FAIL %s done latency: got %0d want %0d", tag, c, (n_pix > 0) ? n_pix + 2 : 1);
        end
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || tri_ready !== 1'b1 || frag_count !== 19'(exp_cnt)) begin
        n_fail++;
        $display("FAIL %s after done: got done=%0b ready=%0b count=%0d want 0 1 %0d",
                 tag, done, tri_ready, frag_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tri_ready !== 1'b1 || frag_valid !== 1'b0 || done !== 1'b0 || frag_count !== '0 ||
        r_x !== '0 || r_y !== '0 || frag_x !== '0) begin
      n_fail++;
      $display("FAIL reset: got ready=%0b valid=%0b done=%0b count=%0d rx=%0d want 1 0 0 0 0",
               tri_ready, frag_valid, done, frag_count, r_x);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel();
    vis_mode = 0; seed = 123;
    run_triangle(5, 5, 7, 7, 100, "one_pixel");
  endtask

  task automatic test_sparse_box();
    vis_mode = 2; vis_px = 2; vis_py = 1; seed = 45;
    run_triangle(0, 3, 0, 1, 100, "sparse4x2");
  endtask

  task automatic test_backpressure();
    vis_mode = 0; seed = 9;
    frag_ready = 1'b0;
    start_tri(20, 21, 3, 3);
    @(negedge clk);
    n_tests++;
    if (frag_valid !== 1'b0 || r_x !== 10'd20) begin
      n_fail++;
      $display("FAIL bp first cycle: got valid=%0b rx=%0d want 0 20", frag_valid, r_x);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (frag_valid !== 1'b1 || frag_x !== 10'd20 || frag_y !== 10'd3 || r_x !== 10'd21 ||
          frag_uw !== uw_f(20, 3, seed)) begin
        n_fail++;
        $display("FAIL bp hold %0d: got v=%0b frag=(%0d,%0d) rx=%0d want 1 (20,3) 21",
                 i, frag_valid, frag_x, frag_y, r_x);
      end
    end
    frag_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (frag_valid !== 1'b1 || frag_x !== 10'd21 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL bp release: got v=%0b fx=%0d done=%0b want 1 21 0", frag_valid, frag_x, done);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || frag_valid !== 1'b0 || frag_count !== 19'd2) begin
      n_fail++;
      $display("FAIL bp done: got done=%0b v=%0b count=%0d want 1 0 2", done, frag_valid, frag_count);
    end
    @(negedge clk);
  endtask

  task automatic test_clamp_empty();
    vis_mode = 0; seed = 77;
    run_triangle(634, 700, 478, 600, 100, "clamp");
    run_triangle(10, 9, 0, 0, 100, "empty_x");
    run_triangle(700, 800, 5, 5, 100, "offscreen");
  endtask

  task automatic test_reset_mid_scan();
    vis_mode = 0; seed = 5;
    frag_ready = 1'b1;
    start_tri(100, 115, 200, 215);
    repeat (20) @(negedge clk);
    n_tests++;
    if (frag_count !== 19'd19) begin
      n_fail++;
      $display("FAIL pre-reset count: got %0d want 19", frag_count);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (tri_ready !== 1'b1 || frag_valid !== 1'b0 || done !== 1'b0 || frag_count !== '0 ||
        r_x !== '0 || r_y !== '0 || frag_x !== '0 || r_ax !== '0) begin
      n_fail++;
      $display("FAIL mid reset: got ready=%0b v=%0b done=%0b count=%0d rx=%0d ry=%0d want 1 0 0 0 0 0",
               tri_ready, frag_valid, done, frag_count, r_x, r_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_triangle(3, 6, 2, 4, 100, "after_reset");
  endtask

  task automatic test_random();
    int mnx, mny;
    for (int i = 0; i < 8; i++) begin
      vis_mode = 1;
      seed = int'($urandom_range(0, 1000));
      mnx = int'($urandom_range(0, 634));
      mny = int'($urandom_range(0, 474));
      run_triangle(mnx, mnx + int'($urandom_range(0, 7)), mny, mny + int'($urandom_range(0, 5)),
                   int'($urandom_range(40, 100)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_sparse_box();
    test_backpressure();
    test_clamp_empty();
    test_reset_mid_scan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
